// File: rtl/core_ctrl_pkg.sv
// Shared control encodings for the core's sequencing logic.
// Used by the pipeline controller, fetch unit and trap logic.
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } ctrl_state_t;

    localparam logic [1:0] PC_SEL_SEQ  = 2'd0;
    localparam logic [1:0] PC_SEL_BR   = 2'd1;
    localparam logic [1:0] PC_SEL_TRAP = 2'd2;

endpackage

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: turns hazard sources
// into per-register stall/flush controls, PC select, and a stall-cycle counter.
module pipe_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int REDIRECT_BUBBLES = 1,
    parameter int MD_TIMEOUT       = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load_use,
    input  logic        i_md_start,
    input  logic        i_md_done,
    input  logic        i_br_taken,
    input  logic        i_trap,
    input  logic        i_mem_busy,
    input  logic        i_fetch_busy,
    output logic        o_pc_stall,
    output logic        o_if_id_stall,
    output logic        o_id_ex_stall,
    output logic        o_ex_mem_stall,
    output logic        o_if_id_flush,
    output logic        o_id_ex_flush,
    output logic        o_ex_mem_flush,
    output logic        o_mem_wb_flush,
    output logic [1:0]  o_pc_sel,
    output logic        o_md_timeout,
    output logic [1:0]  o_state,
    output logic [31:0] o_stall_cnt
);

    localparam logic       HAS_BUBBLES = (REDIRECT_BUBBLES > 0);
    localparam logic [2:0] BUB_LOAD    = 3'(REDIRECT_BUBBLES);
    localparam logic [7:0] MD_LAST     = 8'(MD_TIMEOUT - 1);

    ctrl_state_t r_state;
    ctrl_state_t w_state_next;
    logic [7:0]  r_md_cnt;
    logic [7:0]  w_md_cnt_next;
    logic [2:0]  r_bub_cnt;
    logic [2:0]  w_bub_cnt_next;
    logic [31:0] r_stall_cnt;

    logic        w_redirect;
    logic        w_redirect_trap;

    always_comb begin
        o_pc_stall      = 1'b0;
        o_if_id_stall   = 1'b0;
        o_id_ex_stall   = 1'b0;
        o_ex_mem_stall  = 1'b0;
        o_if_id_flush   = 1'b0;
        o_id_ex_flush   = 1'b0;
        o_ex_mem_flush  = 1'b0;
        o_mem_wb_flush  = 1'b0;
        o_pc_sel        = PC_SEL_SEQ;
        o_md_timeout    = 1'b0;
        w_state_next    = r_state;
        w_md_cnt_next   = r_md_cnt;
        w_bub_cnt_next  = r_bub_cnt;
        w_redirect      = 1'b0;
        w_redirect_trap = 1'b0;

        if (i_rst) begin
            o_if_id_flush  = 1'b1;
            o_id_ex_flush  = 1'b1;
            o_ex_mem_flush = 1'b1;
            o_mem_wb_flush = 1'b1;
        end else if (i_mem_busy) begin
            // Freeze the whole pipe; WB gets a bubble while MEM waits.
            o_pc_stall     = 1'b1;
            o_if_id_stall  = 1'b1;
            o_id_ex_stall  = 1'b1;
            o_ex_mem_stall = 1'b1;
            o_mem_wb_flush = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_trap) begin
                        w_redirect      = 1'b1;
                        w_redirect_trap = 1'b1;
                    end else if (i_md_start && !i_md_done) begin
                        o_pc_stall     = 1'b1;
                        o_if_id_stall  = 1'b1;
                        o_id_ex_stall  = 1'b1;
                        o_ex_mem_flush = 1'b1;
                        w_md_cnt_next  = 8'd1;
                        w_state_next   = ST_MD_WAIT;
                    end else if (i_md_start) begin
                        // Zero-latency mul/div: let it flow.
                    end else if (i_br_taken) begin
                        w_redirect = 1'b1;
                    end else if (i_load_use) begin
                        o_pc_stall    = 1'b1;
                        o_if_id_stall = 1'b1;
                        o_id_ex_flush = 1'b1;
                    end else if (i_fetch_busy) begin
                        o_pc_stall    = 1'b1;
                        o_if_id_flush = 1'b1;
                    end
                end
                ST_MD_WAIT: begin
                    if (i_md_done) begin
                        w_state_next = ST_RUN;
                    end else if (r_md_cnt == MD_LAST) begin
                        o_md_timeout = 1'b1;
                        w_state_next = ST_RUN;
                    end else begin
                        o_pc_stall     = 1'b1;
                        o_if_id_stall  = 1'b1;
                        o_id_ex_stall  = 1'b1;
                        o_ex_mem_flush = 1'b1;
                        w_md_cnt_next  = r_md_cnt + 8'd1;
                    end
                end
                ST_FLUSH: begin
                    if (i_trap) begin
                        w_redirect      = 1'b1;
                        w_redirect_trap = 1'b1;
                    end else begin
                        o_if_id_flush = 1'b1;
                        if (i_fetch_busy) begin
                            o_pc_stall = 1'b1;
                        end else begin
                            w_bub_cnt_next = r_bub_cnt - 3'd1;
                            if (r_bub_cnt == 3'd1) begin
                                w_state_next = ST_RUN;
                            end
                        end
                    end
                end
                default: begin
                    w_state_next = ST_RUN;
                end
            endcase

            if (w_redirect) begin
                o_pc_sel       = w_redirect_trap ? PC_SEL_TRAP : PC_SEL_BR;
                o_if_id_flush  = 1'b1;
                o_id_ex_flush  = 1'b1;
                o_ex_mem_flush = w_redirect_trap;
                if (HAS_BUBBLES) begin
                    w_state_next   = ST_FLUSH;
                    w_bub_cnt_next = BUB_LOAD;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_RUN;
            r_md_cnt    <= 8'd0;
            r_bub_cnt   <= 3'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            r_state   <= w_state_next;
            r_md_cnt  <= w_md_cnt_next;
            r_bub_cnt <= w_bub_cnt_next;
            if (o_pc_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign o_state     = r_state;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table for the sequencing corner cases,
// then random traffic checked against an action-level reference model.
module tb_pipe_ctrl;

    localparam int RB  = 2;
    localparam int MDT = 8;

    // input bits: {rst, load_use, md_start, md_done, br, trap, mem_busy, fetch_busy}
    localparam logic [7:0] RST = 8'h80, LU = 8'h40, MS = 8'h20, MD = 8'h10;
    localparam logic [7:0] BR  = 8'h08, TR = 8'h04, MB = 8'h02, FB = 8'h01;
    // output bits: {pc_s, ifid_s, idex_s, exmem_s, ifid_f, idex_f, exmem_f, memwb_f, sel[1:0], timeout}
    localparam logic [10:0] PS  = 11'h400, IFS = 11'h200, IDS = 11'h100, EXS = 11'h080;
    localparam logic [10:0] IFF = 11'h040, IDF = 11'h020, EXF = 11'h010, MWF = 11'h008;
    localparam logic [10:0] SBR = 11'h002, STR = 11'h004, TO  = 11'h001;
    localparam logic [10:0] O_MD  = PS | IFS | IDS | EXF;
    localparam logic [10:0] O_BUS = PS | IFS | IDS | EXS | MWF;
    localparam logic [10:0] O_TRP = STR | IFF | IDF | EXF;

    logic clk, rst, lu, ms, md, br, tr, mb, fb;
    logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic [1:0] pc_sel, state;
    logic md_timeout;
    logic [31:0] stall_cnt;

    int total = 0;
    int bad = 0;

    pipe_ctrl #(.REDIRECT_BUBBLES(RB), .MD_TIMEOUT(MDT)) dut (
        .i_clk(clk), .i_rst(rst), .i_load_use(lu), .i_md_start(ms), .i_md_done(md),
        .i_br_taken(br), .i_trap(tr), .i_mem_busy(mb), .i_fetch_busy(fb),
        .o_pc_stall(pc_stall), .o_if_id_stall(if_id_stall), .o_id_ex_stall(id_ex_stall),
        .o_ex_mem_stall(ex_mem_stall), .o_if_id_flush(if_id_flush), .o_id_ex_flush(id_ex_flush),
        .o_ex_mem_flush(ex_mem_flush), .o_mem_wb_flush(mem_wb_flush), .o_pc_sel(pc_sel),
        .o_md_timeout(md_timeout), .o_state(state), .o_stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  in;
        logic [10:0] exp;
        logic        chk;
        logic [1:0]  st;
        logic [31:0] cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [7:0] in, input logic [10:0] exp, input logic chk,
                       input logic [1:0] st, input logic [31:0] cnt);
        vec_t v;
        v.in = in; v.exp = exp; v.chk = chk; v.st = st; v.cnt = cnt;
        vq.push_back(v);
    endtask

    task automatic drive(input logic [7:0] v);
        {rst, lu, ms, md, br, tr, mb, fb} = v;
    endtask

    function automatic logic [10:0] outs();
        return {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush,
                ex_mem_flush, mem_wb_flush, pc_sel, md_timeout};
    endfunction

    task automatic check_all(input string tag, input int idx, input logic [10:0] exp,
                             input logic chk, input logic [1:0] st, input logic [31:0] cnt);
        logic [10:0] got;
        got = outs();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d] outputs: got=%011b want=%011b", tag, idx, got, exp);
        end
        if (chk) begin
            total += 2;
            if (state !== st) begin
                bad++;
                $display("FAIL %s[%0d] state: got=%0d want=%0d", tag, idx, state, st);
            end
            if (stall_cnt !== cnt) begin
                bad++;
                $display("FAIL %s[%0d] stall_cnt: got=%0d want=%0d", tag, idx, stall_cnt, cnt);
            end
        end
    endtask

    // Reference model: classify each cycle into the action the rules select.
    localparam int A_RST = 0, A_BUS = 1, A_TRAP = 2, A_MD_GO = 3, A_NOP = 4, A_BR = 5;
    localparam int A_LU = 6, A_FETCH = 7, A_MD_TO = 8, A_BUB = 9, A_BUB_WAIT = 10;

    int m_mode;      // 0 run, 1 mul/div wait, 2 post-redirect bubbles
    int m_md_cycles; // stall cycles already spent on the current mul/div
    int m_bubbles;   // fetch bubbles still to insert
    logic [31:0] m_cnt;

    function automatic int pick_action(input logic [7:0] v);
        if (v[7]) return A_RST;
        if (v[1]) return A_BUS;
        if (m_mode == 0) begin
            if (v[2])          return A_TRAP;
            if (v[5] && !v[4]) return A_MD_GO;
            if (v[5])          return A_NOP;
            if (v[3])          return A_BR;
            if (v[6])          return A_LU;
            if (v[0])          return A_FETCH;
            return A_NOP;
        end
        if (m_mode == 1) begin
            if (v[4])                     return A_NOP;
            if (m_md_cycles == MDT - 1)   return A_MD_TO;
            return A_MD_GO;
        end
        if (v[2]) return A_TRAP;
        return v[0] ? A_BUB_WAIT : A_BUB;
    endfunction

    function automatic logic [10:0] act_out(input int a);
        case (a)
            A_RST:      return IFF | IDF | EXF | MWF;
            A_BUS:      return O_BUS;
            A_TRAP:     return O_TRP;
            A_MD_GO:    return O_MD;
            A_BR:       return SBR | IFF | IDF;
            A_LU:       return PS | IFS | IDF;
            A_FETCH:    return PS | IFF;
            A_MD_TO:    return TO;
            A_BUB:      return IFF;
            A_BUB_WAIT: return PS | IFF;
            default:    return 11'd0;
        endcase
    endfunction

    task automatic model_step(input int a, input logic [7:0] v);
        if (a == A_RST) begin
            m_mode = 0; m_cnt = 0; m_md_cycles = 0; m_bubbles = 0;
            return;
        end
        if (act_out(a) & PS) m_cnt = m_cnt + 1;
        case (a)
            A_TRAP, A_BR: begin m_mode = 2; m_bubbles = RB; end
            A_MD_GO: begin
                if (m_mode == 0) m_md_cycles = 1;
                else m_md_cycles = m_md_cycles + 1;
                m_mode = 1;
            end
            A_MD_TO: m_mode = 0;
            A_BUB: begin
                m_bubbles = m_bubbles - 1;
                if (m_bubbles == 0) m_mode = 0;
            end
            A_NOP: if (m_mode == 1 && v[4]) m_mode = 0;
            default: ;
        endcase
    endtask

    initial begin
        drive(RST);
        // reset with bus busy and trap asserted
        add(RST | MB | TR, IFF | IDF | EXF | MWF, 1'b0, 2'd0, 32'd0);
        add(RST | MB | TR, IFF | IDF | EXF | MWF, 1'b1, 2'd0, 32'd0);
        add(8'h00, 11'h000, 1'b1, 2'd0, 32'd0);
        // single load-use pause
        add(LU, PS | IFS | IDF, 1'b1, 2'd0, 32'd0);
        add(8'h00, 11'h000, 1'b1, 2'd0, 32'd1);
        // mul/div finishing on its 4th cycle
        add(MS, O_MD, 1'b1, 2'd0, 32'd1);
        add(MS, O_MD, 1'b1, 2'd1, 32'd2);
        add(MS, O_MD, 1'b1, 2'd1, 32'd3);
        add(MS | MD, 11'h000, 1'b1, 2'd1, 32'd4);
        add(8'h00, 11'h000, 1'b1, 2'd0, 32'd4);
        // mul/div never completing: forced release after MDT-1 stall cycles
        add(MS, O_MD, 1'b1, 2'd0, 32'd4);
        for (int i = 0; i < 6; i++) add(MS, O_MD, 1'b1, 2'd1, 32'(5 + i));
        add(MS, TO, 1'b1, 2'd1, 32'd11);
        add(8'h00, 11'h000, 1'b1, 2'd0, 32'd11);
        // branch with two redirect bubbles, fetch wait in the second
        add(BR, SBR | IFF | IDF, 1'b1, 2'd0, 32'd11);
        add(8'h00, IFF, 1'b1, 2'd2, 32'd11);
        add(FB, PS | IFF, 1'b1, 2'd2, 32'd11);
        add(8'h00, IFF, 1'b1, 2'd2, 32'd12);
        add(8'h00, 11'h000, 1'b1, 2'd0, 32'd12);
        // bus wait inside mul/div freezes its cycle count
        add(MS, O_MD, 1'b1, 2'd0, 32'd12);
        add(MS, O_MD, 1'b1, 2'd1, 32'd13);
        add(MS | MB, O_BUS, 1'b1, 2'd1, 32'd14);
        add(MS | MB, O_BUS, 1'b1, 2'd1, 32'd15);
        for (int i = 0; i < 5; i++) add(MS, O_MD, 1'b1, 2'd1, 32'(16 + i));
        add(MS, TO, 1'b1, 2'd1, 32'd21);
        add(8'h00, 11'h000, 1'b1, 2'd0, 32'd21);
        // bus wait then done releases
        add(MS, O_MD, 1'b1, 2'd0, 32'd21);
        add(MB, O_BUS, 1'b1, 2'd1, 32'd22);
        add(MD, 11'h000, 1'b1, 2'd1, 32'd23);
        add(8'h00, 11'h000, 1'b1, 2'd0, 32'd23);
        // trap beats branch; trap in bubbles reloads them; others ignored there
        add(TR | BR, O_TRP, 1'b1, 2'd0, 32'd23);
        add(TR, O_TRP, 1'b1, 2'd2, 32'd23);
        add(BR | LU | MS, IFF, 1'b1, 2'd2, 32'd23);
        add(8'h00, IFF, 1'b1, 2'd2, 32'd23);
        add(MS | MD, 11'h000, 1'b1, 2'd0, 32'd23);
        add(FB, PS | IFF, 1'b1, 2'd0, 32'd23);
        add(MB | TR, O_BUS, 1'b1, 2'd0, 32'd24);
        add(8'h00, 11'h000, 1'b1, 2'd0, 32'd25);

        @(posedge clk); #1;
        foreach (vq[i]) begin
            drive(vq[i].in);
            @(negedge clk);
            $display("vec %0d: in=%08b out=%011b state=%0d cnt=%0d",
                     i, vq[i].in, outs(), state, stall_cnt);
            check_all("vec", i, vq[i].exp, vq[i].chk, vq[i].st, vq[i].cnt);
            @(posedge clk); #1;
        end

        m_mode = 0; m_md_cycles = 0; m_bubbles = 0; m_cnt = 0;
        for (int c = 0; c < 1500; c++) begin
            logic [7:0] v;
            int a;
            v[7] = (c == 0) || ($urandom_range(0, 99) == 0);
            v[6] = ($urandom_range(0, 4) == 0);
            v[5] = ($urandom_range(0, 3) == 0);
            v[4] = ($urandom_range(0, 3) == 0);
            v[3] = ($urandom_range(0, 5) == 0);
            v[2] = ($urandom_range(0, 9) == 0);
            v[1] = ($urandom_range(0, 7) == 0);
            v[0] = ($urandom_range(0, 3) == 0);
            drive(v);
            a = pick_action(v);
            @(negedge clk);
            $display("rnd %0d: in=%08b out=%011b state=%0d cnt=%0d", c, v, outs(), state, stall_cnt);
            check_all("rnd", c, act_out(a), (c != 0), 2'(m_mode), m_cnt);
            @(posedge clk); #1;
            model_step(a, v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
